seven_seg_capture: RTL and testbench

Receive-side monitor for the multiplexed 4-digit seven-segment display bus (`led_seg` + `a1..a4`) that `parking_meter` drives. It samples the scanned cathode/anode lines, decodes each digit back to BCD, assembles complete frames, detects dark (blanked) intervals, and measures the flash period. It serves as a bench-side checker of the meter's display path and as an on-board readback of the displayed value.

---
 rtl/seven_seg_pkg.sv | 58 +++++
 rtl/seg_decode.sv | 31 +++
 rtl/seven_seg_capture.sv | 163 ++++++++++++++++
 tb/tb_seven_seg_capture.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low segment patterns, digit codes
// and the anode decode used by both the display encoder and the capture side.
package seven_seg_pkg;

    // Active-low segment patterns, bit [6]=CA ... bit [0]=CG
    localparam logic [6:0] SEG_0   = 7'h01;
    localparam logic [6:0] SEG_1   = 7'h4F;
    localparam logic [6:0] SEG_2   = 7'h12;
    localparam logic [6:0] SEG_3   = 7'h06;
    localparam logic [6:0] SEG_4   = 7'h4C;
    localparam logic [6:0] SEG_5   = 7'h24;
    localparam logic [6:0] SEG_6   = 7'h20;
    localparam logic [6:0] SEG_7   = 7'h0F;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h04;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Non-numeric digit codes
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    // Digit slot index: DIG_1 is the leftmost (thousands) position
    typedef enum logic [1:0] {
        DIG_1 = 2'd0,
        DIG_2 = 2'd1,
        DIG_3 = 2'd2,
        DIG_4 = 2'd3
    } dig_idx_t;

    // Classification of one anode sample
    typedef enum logic [1:0] {
        AN_DARK  = 2'd0,
        AN_ONE   = 2'd1,
        AN_MULTI = 2'd2
    } an_kind_t;

    typedef struct packed {
        an_kind_t kind;
        dig_idx_t idx;
    } an_dec_t;

    // Decode active-low anodes packed as {a1,a2,a3,a4}
    function automatic an_dec_t anode_decode(input logic [3:0] an);
        an_dec_t r;
        r.kind = AN_MULTI;
        r.idx  = DIG_1;
        case (an)
            4'b1111: r.kind = AN_DARK;
            4'b0111: begin r.kind = AN_ONE; r.idx = DIG_1; end
            4'b1011: begin r.kind = AN_ONE; r.idx = DIG_2; end
            4'b1101: begin r.kind = AN_ONE; r.idx = DIG_3; end
            4'b1110: begin r.kind = AN_ONE; r.idx = DIG_4; end
            default: r.kind = AN_MULTI;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment pattern to BCD decoder with error flag.
module seg_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    // Map each legal active-low pattern to its code; anything else is an error
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        code = CODE_ERR;
        err  = 1'b1;
        case (seg)
            SEG_0:   begin code = 4'd0;       err = 1'b0; end
            SEG_1:   begin code = 4'd1;       err = 1'b0; end
            SEG_2:   begin code = 4'd2;       err = 1'b0; end
            SEG_3:   begin code = 4'd3;       err = 1'b0; end
            SEG_4:   begin code = 4'd4;       err = 1'b0; end
            SEG_5:   begin code = 4'd5;       err = 1'b0; end
            SEG_6:   begin code = 4'd6;       err = 1'b0; end
            SEG_7:   begin code = 4'd7;       err = 1'b0; end
            SEG_8:   begin code = 4'd8;       err = 1'b0; end
            SEG_9:   begin code = 4'd9;       err = 1'b0; end
            SEG_OFF: begin code = CODE_BLANK; err = 1'b0; end
            default: begin code = CODE_ERR;   err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment bus: samples
// the scan, rebuilds complete frames, detects blanking and measures the
// flash period between blanking onsets.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int DARK_CYCLES = 4,
    parameter int PW          = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [6:0]    led_seg,
    input  logic          a1,
    input  logic          a2,
    input  logic          a3,
    input  logic          a4,
    output logic [3:0]    dig1,
    output logic [3:0]    dig2,
    output logic [3:0]    dig3,
    output logic [3:0]    dig4,
    output logic          frame_valid,
    output logic          dark,
    output logic [PW-1:0] flash_period,
    output logic          period_valid,
    output logic          seg_err,
    output logic          an_err
);

    localparam int            DW        = $clog2(DARK_CYCLES + 1);
    localparam logic [DW-1:0] DARK_MAX  = DW'(DARK_CYCLES);
    localparam logic [DW-1:0] DARK_LAST = DW'(DARK_CYCLES - 1);

    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    an_dec_t       an_dec;
    logic [3:0]    seg_code;
    logic          seg_bad;
    logic          sample_valid;
    logic          sample_dark;
    logic          dark_rise;
    logic          frame_done;
    logic [3:0]    seen;
    logic [3:0]    seen_upd;
    logic [3:0]    shadow     [0:3];
    logic [3:0]    shadow_upd [0:3];
    logic [3:0]    digs       [0:3];
    logic [DW-1:0] dark_cnt;
    logic [PW-1:0] per_cnt;
    logic          armed;

    // Input stage: register the scanned pins; reset to an idle, dark bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            an_q  <= 4'hF;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            seg_q <= led_seg;
            an_q  <= {a1, a2, a3, a4};
        end
    end

    assign an_dec = anode_decode(an_q);

    seg_decode u_seg_decode (
        .seg  (seg_q),
        .code (seg_code),
        .err  (seg_bad)
    );

    assign sample_valid = (an_dec.kind == AN_ONE);
    assign sample_dark  = (an_dec.kind == AN_DARK) || (sample_valid && (seg_q == SEG_OFF));
    assign dark_rise    = sample_dark && (dark_cnt == DARK_LAST);
    assign dark         = (dark_cnt == DARK_MAX);

    // Fold the current sample into the shadow slots and seen mask
    always_comb begin
        seen_upd = seen;
        for (int i = 0; i < 4; i++) shadow_upd[i] = shadow[i];
        if (sample_valid) begin
            seen_upd[an_dec.idx]   = 1'b1;
            shadow_upd[an_dec.idx] = seg_code;
        end
    end

    assign frame_done = sample_valid && (&seen_upd);

    // Shadow storage for the frame being assembled
    // NOTE: shadows carry no reset; the seen mask alone decides when their contents are trusted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) shadow[i] <= shadow_upd[i];
    end

    // Frame commit: a blanking onset overrides a frame completing in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen        <= 4'b0000;
            frame_valid <= 1'b0;
            for (int i = 0; i < 4; i++) digs[i] <= CODE_BLANK;
        end else if (dark_rise) begin
            seen        <= 4'b0000;
            frame_valid <= 1'b1;
            for (int i = 0; i < 4; i++) digs[i] <= CODE_BLANK;
        end else if (frame_done) begin
            seen        <= 4'b0000;
            frame_valid <= 1'b1;
            for (int i = 0; i < 4; i++) digs[i] <= shadow_upd[i];
        end else begin
            seen        <= seen_upd;
            frame_valid <= 1'b0;
        end
    end

    assign dig1 = digs[0];
    assign dig2 = digs[1];
    assign dig3 = digs[2];
    assign dig4 = digs[3];

    // Count consecutive dark samples, saturating at the dark threshold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dark_cnt <= '0;
        end else if (!sample_dark) begin
            dark_cnt <= '0;
        end else if (dark_cnt != DARK_MAX) begin
            dark_cnt <= dark_cnt + 1'b1;
        end
    end

    // Flash period: cycles between successive blanking onsets, first onset only arms
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt      <= '0;
            armed        <= 1'b0;
            flash_period <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (dark_rise) begin
                if (armed) begin
                    flash_period <= per_cnt;
                    period_valid <= 1'b1;
                end
                armed   <= 1'b1;
                per_cnt <= PW'(1);
            end else if (per_cnt != '1) begin
                per_cnt <= per_cnt + 1'b1;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_err  <= 1'b0;
            seg_err <= 1'b0;
        end else begin
            if (an_dec.kind == AN_MULTI) an_err <= 1'b1;
            if (sample_valid && seg_bad) seg_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: per-cycle vector table plus
// hand sequences for reset mid-frame and flash-period measurement.
module tb_seven_seg_capture;
    import seven_seg_pkg::*;

    localparam logic [3:0] A1 = 4'b0111;
    localparam logic [3:0] A2 = 4'b1011;
    localparam logic [3:0] A3 = 4'b1101;
    localparam logic [3:0] A4 = 4'b1110;
    localparam logic [3:0] DK = 4'b1111;
    localparam logic [3:0] AM = 4'b0011;
    localparam logic [6:0] SEG_BAD = 7'h7E;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  led_seg;
    logic        a1, a2, a3, a4;
    logic [3:0]  dig1, dig2, dig3, dig4;
    logic        frame_valid, dark, period_valid, seg_err, an_err;
    logic [15:0] flash_period;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        fv;
        logic        pv;
        logic        dk;
        logic        se;
        logic        ae;
        logic [15:0] dig;
        logic [15:0] fp;
    } vec_t;

    vec_t tbl [34];
    vec_t post[6];

    seven_seg_capture #(.DARK_CYCLES(4), .PW(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .led_seg      (led_seg),
        .a1           (a1),
        .a2           (a2),
        .a3           (a3),
        .a4           (a4),
        .dig1         (dig1),
        .dig2         (dig2),
        .dig3         (dig3),
        .dig4         (dig4),
        .frame_valid  (frame_valid),
        .dark         (dark),
        .flash_period (flash_period),
        .period_valid (period_valid),
        .seg_err      (seg_err),
        .an_err       (an_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] an, input logic [6:0] seg,
                                input logic fv, input logic pv, input logic dk,
                                input logic se, input logic ae,
                                input logic [15:0] dig, input logic [15:0] fp);
        vec_t v;
        v.an = an; v.seg = seg; v.fv = fv; v.pv = pv; v.dk = dk;
        v.se = se; v.ae = ae; v.dig = dig; v.fp = fp;
        return v;
    endfunction

    task automatic drive(input logic [3:0] an, input logic [6:0] seg);
        {a1, a2, a3, a4} = an;
        led_seg = seg;
    endtask

    // Apply one vector now (just after a falling edge), then check one cycle later
    task automatic run_vec(input vec_t v, input string tag);
        drive(v.an, v.seg);
        @(negedge clk);
        check({tag, "_fv"},  frame_valid,  v.fv);
        check({tag, "_pv"},  period_valid, v.pv);
        check({tag, "_dark"}, dark,        v.dk);
        check({tag, "_errs"}, {seg_err, an_err}, {v.se, v.ae});
        check({tag, "_dig"}, {dig1, dig2, dig3, dig4}, v.dig);
        check({tag, "_fp"},  flash_period, v.fp);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dig"}, {dig1, dig2, dig3, dig4}, 16'hFFFF);
        check({tag, "_pulses"}, {frame_valid, period_valid}, 2'b00);
        check({tag, "_dark"}, dark, 1'b0);
        check({tag, "_errs"}, {seg_err, an_err}, 2'b00);
        check({tag, "_fp"}, flash_period, 16'd0);
    endtask

    initial begin
        logic [3:0] lit_an  [4];
        logic [6:0] lit_seg [4];
        int         rises;
        logic       prev_dark;

        //               an  seg      fv pv dk se ae dig       fp
        tbl[0]  = mk(A1, SEG_1,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        tbl[1]  = mk(A2, SEG_2,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        tbl[2]  = mk(A3, SEG_3,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        tbl[3]  = mk(A4, SEG_4,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        tbl[4]  = mk(A1, SEG_0,   1, 0, 0, 0, 0, 16'h1234, 16'd0);
        tbl[5]  = mk(A2, SEG_1,   0, 0, 0, 0, 0, 16'h1234, 16'd0);
        tbl[6]  = mk(DK, SEG_OFF, 0, 0, 0, 0, 0, 16'h1234, 16'd0);
        tbl[7]  = mk(A3, SEG_8,   0, 0, 0, 0, 0, 16'h1234, 16'd0);
        tbl[8]  = mk(A4, SEG_0,   0, 0, 0, 0, 0, 16'h1234, 16'd0);
        tbl[9]  = mk(DK, SEG_OFF, 1, 0, 0, 0, 0, 16'h0180, 16'd0);
        tbl[10] = mk(DK, SEG_OFF, 0, 0, 0, 0, 0, 16'h0180, 16'd0);
        tbl[11] = mk(DK, SEG_OFF, 0, 0, 0, 0, 0, 16'h0180, 16'd0);
        tbl[12] = mk(DK, SEG_OFF, 0, 0, 0, 0, 0, 16'h0180, 16'd0);
        tbl[13] = mk(DK, SEG_OFF, 1, 0, 1, 0, 0, 16'hFFFF, 16'd0);
        tbl[14] = mk(DK, SEG_OFF, 0, 0, 1, 0, 0, 16'hFFFF, 16'd0);
        tbl[15] = mk(A1, SEG_5,   0, 0, 1, 0, 0, 16'hFFFF, 16'd0);
        tbl[16] = mk(A2, SEG_6,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        tbl[17] = mk(A3, SEG_7,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        tbl[18] = mk(A4, SEG_9,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        tbl[19] = mk(A3, SEG_BAD, 1, 0, 0, 0, 0, 16'h5679, 16'd0);
        tbl[20] = mk(A1, SEG_9,   0, 0, 0, 1, 0, 16'h5679, 16'd0);
        tbl[21] = mk(A2, SEG_9,   0, 0, 0, 1, 0, 16'h5679, 16'd0);
        tbl[22] = mk(A4, SEG_9,   0, 0, 0, 1, 0, 16'h5679, 16'd0);
        tbl[23] = mk(AM, SEG_3,   1, 0, 0, 1, 0, 16'h99E9, 16'd0);
        tbl[24] = mk(A1, SEG_1,   0, 0, 0, 1, 1, 16'h99E9, 16'd0);
        tbl[25] = mk(A2, SEG_2,   0, 0, 0, 1, 1, 16'h99E9, 16'd0);
        tbl[26] = mk(A3, SEG_3,   0, 0, 0, 1, 1, 16'h99E9, 16'd0);
        tbl[27] = mk(A4, SEG_4,   0, 0, 0, 1, 1, 16'h99E9, 16'd0);
        tbl[28] = mk(A1, SEG_OFF, 1, 0, 0, 1, 1, 16'h1234, 16'd0);
        tbl[29] = mk(A2, SEG_OFF, 0, 0, 0, 1, 1, 16'h1234, 16'd0);
        tbl[30] = mk(A3, SEG_OFF, 0, 0, 0, 1, 1, 16'h1234, 16'd0);
        tbl[31] = mk(A4, SEG_OFF, 0, 0, 0, 1, 1, 16'h1234, 16'd0);
        tbl[32] = mk(A1, SEG_1,   1, 1, 1, 1, 1, 16'hFFFF, 16'd19);
        tbl[33] = mk(A2, SEG_2,   0, 0, 0, 1, 1, 16'hFFFF, 16'd19);

        // After a mid-frame reset: digits 3,4,1 must not complete a frame
        post[0] = mk(A3, SEG_3,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        post[1] = mk(A4, SEG_4,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        post[2] = mk(A1, SEG_1,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        post[3] = mk(A2, SEG_2,   0, 0, 0, 0, 0, 16'hFFFF, 16'd0);
        post[4] = mk(A2, SEG_2,   1, 0, 0, 0, 0, 16'h1234, 16'd0);
        post[5] = mk(A2, SEG_2,   0, 0, 0, 0, 0, 16'h1234, 16'd0);

        lit_an[0]  = A1; lit_an[1]  = A2; lit_an[2]  = A3; lit_an[3]  = A4;
        lit_seg[0] = SEG_1; lit_seg[1] = SEG_2; lit_seg[2] = SEG_3; lit_seg[3] = SEG_4;

        // Reset with an idle, dark bus
        rst = 1'b1;
        drive(DK, SEG_OFF);
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < 34; i++) run_vec(tbl[i], $sformatf("row%0d", i));

        // Reset after digits 1 and 2 have been captured
        @(negedge clk);
        rst = 1'b1;
        drive(A3, SEG_3);
        #1;
        check_reset_state("midreset");
        @(negedge clk);
        check_reset_state("midreset_hold");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) run_vec(post[i], $sformatf("post%0d", i));

        // Flash measurement: 50 lit / 50 dark, three periods
        rises     = 0;
        prev_dark = dark;
        for (int b = 0; b < 3; b++) begin
            for (int c = 0; c < 100; c++) begin
                if (c < 50) drive(lit_an[c % 4], lit_seg[c % 4]);
                else        drive(DK, SEG_OFF);
                @(negedge clk);
                if (dark && !prev_dark) begin
                    rises++;
                    check($sformatf("flash_pv_onset%0d", rises), period_valid, (rises > 1));
                    if (rises > 1)
                        check($sformatf("flash_period_onset%0d", rises), flash_period, 16'd100);
                end else begin
                    check($sformatf("flash_pv_quiet_b%0d_c%0d", b, c), period_valid, 1'b0);
                end
                prev_dark = dark;
            end
        end
        check("flash_onsets", rises, 3);
        check("flash_final_period", flash_period, 16'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
